// File: rtl/harris_pkg.sv
// Shared widths, FSM state type and corner record for the Harris corner collector.
package harris_pkg;

    localparam int FEATURE_W = 54;
    localparam int CX_W      = 10;
    localparam int CY_W      = 9;
    localparam int COUNT_W   = 16;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [CY_W-1:0] y;
        logic [CX_W-1:0] x;
    } corner_t;

    localparam logic signed [FEATURE_W-1:0] FEATURE_MIN = {1'b1, {(FEATURE_W-1){1'b0}}};

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        logic [COUNT_W-1:0] result;
        if (value == {COUNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/corner_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible whenever not empty.
module corner_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;
    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam lvl_t LVL_ONE  = lvl_t'(1);
    localparam lvl_t LVL_FULL = lvl_t'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    ptr_t             wr_ptr_r;
    ptr_t             rd_ptr_r;
    lvl_t             level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == '0);
    assign do_pop_s  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head read; forced to zero while empty so stale entries never show.
    always_comb begin
        rdata = '0;
        if (empty) begin
            rdata = '0;
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/harris_corner_collector.sv
// Tracks pixel coordinates of the Harris score stream, applies threshold plus 1x3
// horizontal non-maximum suppression, and queues surviving corners for a host reader.
module harris_corner_collector
    import harris_pkg::*;
#(
    parameter int P_WIDTH      = 640,
    parameter int P_HEIGHT     = 480,
    parameter int P_X_OFS      = 3,
    parameter int P_Y_OFS      = 2,
    parameter int P_FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic                        frame_start,
    input  logic signed [FEATURE_W-1:0] harris_feature,
    input  logic signed [FEATURE_W-1:0] threshold,
    output logic                        corner_valid,
    output logic        [CX_W-1:0]      corner_x,
    output logic        [CY_W-1:0]      corner_y,
    input  logic                        corner_ready,
    output logic        [COUNT_W-1:0]   corner_count,
    output logic                        overflow,
    output logic                        frame_done
);

    typedef logic [CX_W-1:0] cx_t;
    typedef logic [CY_W-1:0] cy_t;
    localparam cx_t X_LAST = cx_t'(P_WIDTH - 1);
    localparam cy_t Y_LAST = cy_t'(P_HEIGHT - 1);
    localparam cx_t X_OFS  = cx_t'(P_X_OFS);
    localparam cy_t Y_OFS  = cy_t'(P_Y_OFS);
    localparam cx_t X_ONE  = cx_t'(1);
    localparam cx_t X_TWO  = cx_t'(2);
    localparam cy_t Y_ONE  = cy_t'(1);

    state_t                      state_r;
    state_t                      state_s;
    cx_t                         x_r;
    cy_t                         y_r;
    logic signed [FEATURE_W-1:0] w0_r;
    logic signed [FEATURE_W-1:0] w1_r;
    logic [COUNT_W-1:0]          count_r;
    logic                        overflow_r;
    logic                        done_r;

    logic    start_s;
    logic    sample_s;
    logic    last_s;
    logic    cand_s;
    logic    keep_s;
    logic    push_s;
    logic    pop_s;
    logic    push_ok_s;
    logic    drop_s;
    logic    full_s;
    logic    empty_s;
    corner_t push_data_s;
    corner_t head_s;

    assign start_s  = clk_en & frame_start;
    assign sample_s = clk_en & ~frame_start & (state_r == S_ACTIVE);
    assign last_s   = sample_s & (x_r == X_LAST) & (y_r == Y_LAST);

    // The centre sample sits at column x-1; w1 is its left and the input its right neighbour.
    assign cand_s = sample_s & (x_r >= X_TWO) & (w0_r > threshold) &
                    (w0_r > w1_r) & (w0_r >= harris_feature);
    // Centre column minus the stream lag must not go negative, which is x > X_OFS.
    assign keep_s = (x_r > X_OFS) & (y_r >= Y_OFS);
    assign push_s = cand_s & keep_s;

    assign push_data_s.x = x_r - X_ONE - X_OFS;
    assign push_data_s.y = y_r - Y_OFS;

    assign corner_valid = ~empty_s;
    assign corner_x     = head_s.x;
    assign corner_y     = head_s.y;
    assign pop_s        = corner_valid & corner_ready;
    assign push_ok_s    = push_s & (~full_s | pop_s);
    assign drop_s       = push_s & full_s & ~pop_s;

    assign corner_count = count_r;
    assign overflow     = overflow_r;
    assign frame_done   = done_r;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; frame_start always (re)starts a frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    state_s = S_ACTIVE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (start_s) begin
                    state_s = S_ACTIVE;
                end else if (last_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_ACTIVE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Pixel counters and the two-deep row window.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r  <= '0;
            y_r  <= '0;
            w0_r <= FEATURE_MIN;
            w1_r <= FEATURE_MIN;
        end else if (start_s) begin
            x_r  <= X_ONE;
            y_r  <= '0;
            w0_r <= harris_feature;
            w1_r <= FEATURE_MIN;
        end else if (sample_s) begin
            if (x_r == X_LAST) begin
                x_r  <= '0;
                y_r  <= (y_r == Y_LAST) ? '0 : (y_r + Y_ONE);
                w0_r <= FEATURE_MIN;
                w1_r <= FEATURE_MIN;
            end else begin
                x_r  <= x_r + X_ONE;
                w0_r <= harris_feature;
                w1_r <= w0_r;
            end
        end
    end

    // Per-frame status: done pulse, accepted-corner count and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= '0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= last_s;
            if (start_s && (state_r == S_IDLE)) begin
                count_r    <= '0;
                overflow_r <= 1'b0;
            end else begin
                if (push_ok_s) begin
                    count_r <= sat_inc(count_r);
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    corner_fifo #(
        .WIDTH ($bits(corner_t)),
        .DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (push_data_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: tb/tb_harris_corner_collector.sv
// Directed plus randomized frames against a frame-level corner model; dut_a uses zero
// offsets and a 4-deep FIFO, dut_b shares the stream with offsets (3,2).
module tb_harris_corner_collector;

    localparam int W = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1;
    logic               clk_en = 1'b0;
    logic               frame_start = 1'b0;
    logic               corner_ready = 1'b1;
    logic signed [53:0] harris_feature = '0;
    logic signed [53:0] threshold = 54'sd100;

    logic        va, oa, da, vb, ob, db;
    logic [9:0]  xa, xb;
    logic [8:0]  ya, yb;
    logic [15:0] ca, cb;

    harris_corner_collector #(.P_WIDTH(W), .P_HEIGHT(H), .P_X_OFS(0), .P_Y_OFS(0),
                              .P_FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .frame_start(frame_start),
        .harris_feature(harris_feature), .threshold(threshold),
        .corner_valid(va), .corner_x(xa), .corner_y(ya), .corner_ready(corner_ready),
        .corner_count(ca), .overflow(oa), .frame_done(da));

    harris_corner_collector #(.P_WIDTH(W), .P_HEIGHT(H), .P_X_OFS(3), .P_Y_OFS(2),
                              .P_FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .frame_start(frame_start),
        .harris_feature(harris_feature), .threshold(threshold),
        .corner_valid(vb), .corner_x(xb), .corner_y(yb), .corner_ready(corner_ready),
        .corner_count(cb), .overflow(ob), .frame_done(db));

    int     checks = 0;
    int     failures = 0;
    longint frame [H][W];
    bit     is_corner [H][W];
    int     exp_q [$];
    int     got_b [$];
    int     n_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check the FIFO head against the model queue, then retire it on a pop.
    task automatic tick();
        bit pop_a;
        pop_a = 1'b0;
        if (va === 1'b1) begin
            if (exp_q.size() == 0) chk("head_unexpected", {31'd0, va}, 32'd0);
            else                   chk("head_xy", {13'd0, ya, xa}, exp_q[0]);
            pop_a = corner_ready;
        end
        if (vb === 1'b1 && corner_ready) got_b.push_back(int'({yb, xb}));
        @(posedge clk);
        if (pop_a && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic clear_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) frame[y][x] = 0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1; clk_en = 1'b0; frame_start = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    function automatic longint rnd_score();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)      return -(64'sd1 <<< 52);
        else if (r == 1) return (64'sd1 <<< 52) + longint'($urandom_range(0, 3));
        else             return longint'($urandom_range(0, 5)) * 60 - 60;
    endfunction

    // Feeds frame[][] as one frame; with model_en the expected corners are derived from it.
    task automatic run_frame(input bit model_en, input bit gaps, input longint thr);
        threshold = 54'(thr);
        n_exp = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) is_corner[y][x] = 1'b0;
            if (model_en) begin
                for (int c = 1; c < W - 1; c++) begin
                    if (frame[y][c] > thr && frame[y][c] > frame[y][c-1] &&
                        frame[y][c] >= frame[y][c+1]) begin
                        is_corner[y][c] = 1'b1;
                        exp_q.push_back(y * 1024 + c);
                        n_exp++;
                    end
                end
            end
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps) begin
                    while ($urandom_range(0, 3) == 0) begin
                        clk_en = 1'b0; frame_start = 1'b0;
                        tick();
                    end
                end
                clk_en = 1'b1;
                frame_start = (x == 0 && y == 0);
                harris_feature = 54'(frame[y][x]);
                tick();
                chk("frame_done", {31'd0, da}, {31'd0, (x == W - 1 && y == H - 1)});
                if (model_en && x >= 2 && is_corner[y][x-1]) chk("latency_valid", {31'd0, va}, 32'd1);
            end
        end
        clk_en = 1'b0; frame_start = 1'b0;
        tick();
        chk("done_one_cycle", {31'd0, da}, 32'd0);
    endtask

    task automatic drain_check();
        clk_en = 1'b0; frame_start = 1'b0;
        repeat (6) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("valid_after_drain", {31'd0, va}, 32'd0);
        chk("count", {16'd0, ca}, n_exp);
        chk("overflow_clear", {31'd0, oa}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        tick();
        reset_pulse();
        chk("rst_valid", {31'd0, va}, 32'd0);
        chk("rst_xy", {13'd0, ya, xa}, 32'd0);
        chk("rst_count", {16'd0, ca}, 32'd0);
        chk("rst_overflow", {31'd0, oa}, 32'd0);
        chk("rst_done", {31'd0, da}, 32'd0);

        // Single peak at (3,1).
        corner_ready = 1'b1;
        clear_frame(); frame[1][3] = 500;
        run_frame(1'b1, 1'b0, 100);
        drain_check();
        chk("single_peak_count", {16'd0, ca}, 32'd1);

        // Plateau resolves to the left sample only.
        clear_frame(); frame[0][1] = 200; frame[0][2] = 200;
        run_frame(1'b1, 1'b0, 100);
        drain_check();
        chk("plateau_count", {16'd0, ca}, 32'd1);

        // Edge columns and row wrap never yield corners.
        clear_frame(); frame[0][7] = 900; frame[1][0] = 900;
        run_frame(1'b1, 1'b0, 100);
        drain_check();
        chk("edge_count", {16'd0, ca}, 32'd0);

        // Overflow: six peaks into a 4-deep FIFO that is not being read.
        corner_ready = 1'b0;
        clear_frame();
        for (int k = 1; k < 6; k += 2) begin frame[0][k] = 500; frame[1][k] = 500; end
        exp_q = '{1, 3, 5, 1024 + 1};
        run_frame(1'b0, 1'b0, 100);
        chk("ovf_count", {16'd0, ca}, 32'd4);
        chk("ovf_flag", {31'd0, oa}, 32'd1);
        chk("ovf_valid", {31'd0, va}, 32'd1);
        corner_ready = 1'b1;
        repeat (4) tick();
        chk("ovf_popped_all", exp_q.size(), 32'd0);
        chk("ovf_valid_empty", {31'd0, va}, 32'd0);
        chk("ovf_sticky", {31'd0, oa}, 32'd1);
        clear_frame();
        run_frame(1'b1, 1'b0, 100);
        drain_check();

        // Reset with two corners queued, then samples without frame_start are ignored.
        corner_ready = 1'b0;
        clear_frame(); frame[0][1] = 500; frame[0][3] = 500;
        exp_q = '{1, 3};
        threshold = 54'sd100;
        for (int x = 0; x < 5; x++) begin
            clk_en = 1'b1; frame_start = (x == 0); harris_feature = 54'(frame[0][x]);
            tick();
        end
        chk("pre_reset_count", {16'd0, ca}, 32'd2);
        reset_pulse();
        chk("post_reset_valid", {31'd0, va}, 32'd0);
        chk("post_reset_count", {16'd0, ca}, 32'd0);
        corner_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clk_en = 1'b1; frame_start = 1'b0;
            harris_feature = (i % 2 == 1) ? 54'sd500 : 54'sd0;
            tick();
            chk("idle_ignored", {31'd0, va}, 32'd0);
        end
        chk("idle_count", {16'd0, ca}, 32'd0);

        // Offsets on dut_b: centre (2,3) and (4,1) discarded, centre (4,3) reported as (1,1).
        reset_pulse();
        got_b.delete();
        clear_frame(); frame[3][2] = 500; frame[3][4] = 500; frame[1][4] = 500;
        run_frame(1'b1, 1'b0, 100);
        drain_check();
        chk("ofs_b_entries", got_b.size(), 32'd1);
        if (got_b.size() > 0) chk("ofs_b_xy", got_b[0], 32'd1025);
        chk("ofs_b_count", {16'd0, cb}, 32'd1);
        chk("ofs_b_overflow", {31'd0, ob}, 32'd0);

        // Randomized frames with clk_en gaps and wide signed scores.
        for (int f = 0; f < 6; f++) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) frame[y][x] = rnd_score();
            run_frame(1'b1, 1'b1, longint'($urandom_range(0, 150)) - 20);
            drain_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
